// File: rtl/stable_match_pkg.sv
// -----------------------------------------------------------------------------
// stable_match_pkg
// Shared definitions for the stable-matching checker:
//   - log2()      : index width for a table of x entries (never below 1 bit)
//   - state_e     : checker FSM encoding, also driven out on the debug port
//   - pref_base() : bit offset of man i's j-th choice inside the packed m_pref
//   - rank_base() : bit offset of woman w's rank of man m inside packed w_rank
// -----------------------------------------------------------------------------
package stable_match_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_INVERT = 2'd1,
      ST_SCAN   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // ceil(log2(x)). A single-entry table still needs a 1-bit index so that
   // no port collapses to zero width.
   function automatic int log2(input int x);
      int r;
      r = 0;
      while ((1 << r) < x) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int pref_base(input int i, input int j, input int km, input int log_w);
      return (i * km + j) * log_w;
   endfunction

   function automatic int rank_base(input int w, input int m, input int n_m, input int log_kw);
      return (w * n_m + m) * log_kw;
   endfunction

endpackage

// File: rtl/stable_match_checker_partner_table.sv
// -----------------------------------------------------------------------------
// m_partner_table
// Per-man partner register file: man -> woman index plus a "man is matched"
// flag. Written once per woman during the inversion pass, read by the scan.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset (clears table)
//   clear_i        : synchronous clear of all entries and flags
//   we_i           : write enable (ignored while clear_i is high)
//   waddr_i        : man index to write
//   wdata_i        : woman index stored for that man
//   raddr_i        : man index for the combinational read port
//   rdata_o        : stored woman for raddr_i
//   rmatched_o     : 1 when raddr_i has been written since the last clear
// -----------------------------------------------------------------------------
module m_partner_table
   import stable_match_pkg::*;
#(
   parameter int M     = 8,
   parameter int LOG_M = 3,
   parameter int LOG_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             we_i,
   input  logic [LOG_M-1:0] waddr_i,
   input  logic [LOG_W-1:0] wdata_i,
   input  logic [LOG_M-1:0] raddr_i,
   output logic [LOG_W-1:0] rdata_o,
   output logic             rmatched_o
);

   logic [LOG_W-1:0] partner_q [M];
   logic [M-1:0]     matched_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < M; i++) partner_q[i] <= '0;
         matched_q <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < M; i++) partner_q[i] <= '0;
         matched_q <= '0;
      end else if (we_i) begin
         // A later write to the same man simply overwrites the earlier one.
         partner_q[waddr_i] <= wdata_i;
         matched_q[waddr_i] <= 1'b1;
      end
   end

   assign rdata_o    = partner_q[raddr_i];
   assign rmatched_o = matched_q[raddr_i];

endmodule

// File: rtl/stable_match_checker.sv
// -----------------------------------------------------------------------------
// stable_match_checker
// Validates a woman->man matching against both preference tables and reports
// either "stable" or the first blocking (man, woman) pair in scan order.
// Protocol: start is a request sampled only in IDLE; the caller holds all data
// inputs steady until done. done is a one-cycle pulse; stable/blocking_* stay
// valid until the next accepted start. There is no back-pressure.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a check (ignored unless idle)
//   match_list   : man matched to woman w at [w*LOG_M +: LOG_M]
//   w_valid      : bit w set when woman w is matched
//   m_pref       : man i's j-th choice at [(i*Km+j)*LOG_W +: LOG_W], j=0 best
//   w_rank       : woman w's rank of man m at [(w*M+m)*LOG_KW +: LOG_KW]
//   busy         : high while inverting or scanning
//   done         : result-valid pulse
//   stable       : 1 = no blocking pair found
//   blocking_m/w : first blocking pair (zero when stable)
//   state_dbg_o  : current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module stable_match_checker
   import stable_match_pkg::*;
#(
   parameter int Kw = 8,
   parameter int Km = 8,
   parameter int M  = 8,
   parameter int W  = 8,
   localparam int LOG_M  = log2(M),
   localparam int LOG_W  = log2(W),
   localparam int LOG_KM = log2(Km),
   localparam int LOG_KW = log2(Kw)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [W*LOG_M-1:0]       match_list,
   input  logic [W-1:0]             w_valid,
   input  logic [M*Km*LOG_W-1:0]    m_pref,
   input  logic [W*M*LOG_KW-1:0]    w_rank,
   output logic                     busy,
   output logic                     done,
   output logic                     stable,
   output logic [LOG_M-1:0]         blocking_m,
   output logic [LOG_W-1:0]         blocking_w,
   output logic [1:0]               state_dbg_o
);

   state_e            state_q;
   logic [LOG_W-1:0]  wi_q;
   logic [LOG_M-1:0]  mi_q;
   logic [LOG_KM-1:0] k_q;
   logic              busy_q, done_q, stable_q;
   logic [LOG_M-1:0]  bm_q;
   logic [LOG_W-1:0]  bw_q;

   // Inversion pass signals
   logic [LOG_M-1:0]  inv_man;
   logic              tbl_clear, tbl_we;

   // Scan pass signals
   logic [LOG_W-1:0]  p_partner;
   logic              p_matched;
   logic [LOG_W-1:0]  cand_w;
   logic              cand_in_range;
   logic [LOG_M-1:0]  cand_man;
   logic              cand_valid;
   logic [LOG_KW-1:0] rank_new, rank_cur;
   logic              is_partner, is_blocking;
   logic              last_k, last_m;

   always_comb begin
      inv_man   = match_list[int'(wi_q) * LOG_M +: LOG_M];
      tbl_clear = (state_q == ST_IDLE) && start;
      // Out-of-range man numbers are silently skipped.
      tbl_we    = (state_q == ST_INVERT) && w_valid[wi_q] && (int'(inv_man) < M);
   end

   m_partner_table #(
      .M     (M),
      .LOG_M (LOG_M),
      .LOG_W (LOG_W)
   ) u_partner_table (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (tbl_clear),
      .we_i       (tbl_we),
      .waddr_i    (inv_man),
      .wdata_i    (wi_q),
      .raddr_i    (mi_q),
      .rdata_o    (p_partner),
      .rmatched_o (p_matched)
   );

   always_comb begin
      cand_w        = m_pref[pref_base(int'(mi_q), int'(k_q), Km, LOG_W) +: LOG_W];
      cand_in_range = int'(cand_w) < W;
      cand_man      = cand_in_range ? match_list[int'(cand_w) * LOG_M +: LOG_M] : '0;
      // "Validly matched": flagged and naming a real man.
      cand_valid    = cand_in_range && w_valid[cand_w] && (int'(cand_man) < M);
      rank_new      = '0;
      rank_cur      = '0;
      if (cand_valid) begin
         rank_new = w_rank[rank_base(int'(cand_w), int'(mi_q), M, LOG_KW) +: LOG_KW];
         rank_cur = w_rank[rank_base(int'(cand_w), int'(cand_man), M, LOG_KW) +: LOG_KW];
      end
      is_partner  = p_matched && (cand_w == p_partner);
      // Strictly-better rank only: ties do not block.
      is_blocking = cand_in_range && !is_partner && (!cand_valid || (rank_new < rank_cur));
      last_k      = int'(k_q) == Km - 1;
      last_m      = int'(mi_q) == M - 1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wi_q     <= '0;
         mi_q     <= '0;
         k_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         stable_q <= 1'b0;
         bm_q     <= '0;
         bw_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_INVERT;
                  wi_q    <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_INVERT: begin
               if (int'(wi_q) == W - 1) begin
                  state_q <= ST_SCAN;
                  mi_q    <= '0;
                  k_q     <= '0;
               end else begin
                  wi_q <= wi_q + LOG_W'(1);
               end
            end
            ST_SCAN: begin
               if (is_blocking) begin
                  stable_q <= 1'b0;
                  bm_q     <= mi_q;
                  bw_q     <= cand_w;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end else if (is_partner || last_k) begin
                  // Pairs ranked below a man's own partner cannot block.
                  if (last_m) begin
                     stable_q <= 1'b1;
                     bm_q     <= '0;
                     bw_q     <= '0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= ST_DONE;
                  end else begin
                     mi_q <= mi_q + LOG_M'(1);
                     k_q  <= '0;
                  end
               end else begin
                  k_q <= k_q + LOG_KM'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign stable      = stable_q;
   assign blocking_m  = bm_q;
   assign blocking_w  = bw_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_stable_match_checker.sv
// -----------------------------------------------------------------------------
// tb_stable_match_checker
// Directed and random checks of stable_match_checker with M=W=Km=Kw=4.
// Expected results come from a small array-based model of the matching rules.
// -----------------------------------------------------------------------------
module tb_stable_match_checker;

   localparam int M  = 4;
   localparam int W  = 4;
   localparam int KM = 4;
   localparam int KW = 4;
   localparam int LM = 2;
   localparam int LW = 2;
   localparam int LK = 2;
   localparam int BUDGET = 200;

   logic              clk;
   logic              rst;
   logic              start;
   logic [W*LM-1:0]   match_list;
   logic [W-1:0]      w_valid;
   logic [M*KM*LW-1:0] m_pref;
   logic [W*M*LK-1:0] w_rank;
   logic              busy, done, stable;
   logic [LM-1:0]     blocking_m;
   logic [LW-1:0]     blocking_w;
   logic [1:0]        state_dbg;

   stable_match_checker #(.Kw(KW), .Km(KM), .M(M), .W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .match_list  (match_list),
      .w_valid     (w_valid),
      .m_pref      (m_pref),
      .w_rank      (w_rank),
      .busy        (busy),
      .done        (done),
      .stable      (stable),
      .blocking_m  (blocking_m),
      .blocking_w  (blocking_w),
      .state_dbg_o (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scenario tables ----------------
   int pref   [M][KM];
   int rank_t [W][M];
   int ml     [W];
   bit wv     [W];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < M; i++)
         for (int j = 0; j < KM; j++)
            m_pref[(i*KM+j)*LW +: LW] = LW'(pref[i][j]);
      for (int w = 0; w < W; w++) begin
         for (int m = 0; m < M; m++)
            w_rank[(w*M+m)*LK +: LK] = LK'(rank_t[w][m]);
         match_list[w*LM +: LM] = LM'(ml[w]);
         w_valid[w] = wv[w];
      end
   endtask

   // Reference: build each man's partner from the women (later woman wins),
   // then walk every man's list in order until a blocking pair is found.
   function automatic void model(output bit st, output int bm, output int bw, output int n);
      int partner [M];
      bit pm [M];
      int w;
      for (int m = 0; m < M; m++) begin partner[m] = 0; pm[m] = 0; end
      for (int x = 0; x < W; x++)
         if (wv[x] && ml[x] < M) begin partner[ml[x]] = x; pm[ml[x]] = 1; end
      st = 1; bm = 0; bw = 0; n = 0;
      for (int m = 0; m < M; m++) begin
         for (int k = 0; k < KM; k++) begin
            w = pref[m][k];
            n++;
            if (w >= W) continue;
            if (pm[m] && w == partner[m]) break;
            if (!wv[w] || ml[w] >= M || rank_t[w][m] < rank_t[w][ml[w]]) begin
               st = 0; bm = m; bw = w;
               return;
            end
         end
      end
   endfunction

   task automatic set_identity();
      for (int i = 0; i < M; i++)
         for (int k = 0; k < KM; k++) pref[i][k] = k;
      for (int w = 0; w < W; w++) begin
         for (int m = 0; m < M; m++) rank_t[w][m] = m;
         ml[w] = w;
         wv[w] = 1;
      end
   endtask

   task automatic set_full_scan();
      for (int i = 0; i < M; i++)
         for (int k = 0; k < KM; k++) pref[i][k] = KM - 1 - k;
      pref[0][0] = 1; pref[0][1] = 2; pref[0][2] = 3; pref[0][3] = 0;
      for (int w = 0; w < W; w++) begin
         for (int m = 0; m < M; m++)
            rank_t[w][m] = (m == w) ? 0 : ((m < w) ? m + 1 : m);
         ml[w] = w;
         wv[w] = 1;
      end
   endtask

   task automatic set_random();
      for (int i = 0; i < M; i++)
         for (int k = 0; k < KM; k++) pref[i][k] = $urandom_range(0, W-1);
      for (int w = 0; w < W; w++) begin
         for (int m = 0; m < M; m++) rank_t[w][m] = $urandom_range(0, KW-1);
         ml[w] = $urandom_range(0, M-1);
         wv[w] = ($urandom_range(0, 3) != 0);
      end
   endtask

   // One full check: start, wait for done, compare latency and result.
   task automatic run_case(input string tag);
      bit st;
      int bm, bw, n, e;
      apply();
      model(st, bm, bw, n);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, ".busy"}, busy, 1);
      e = 0;
      while (!done && e < BUDGET) begin
         @(negedge clk);
         e++;
      end
      check({tag, ".latency"}, e, W + n);
      check({tag, ".stable"}, stable, st);
      check({tag, ".blk_m"}, blocking_m, bm);
      check({tag, ".blk_w"}, blocking_w, bw);
      check({tag, ".busy_at_done"}, busy, 0);
      @(negedge clk);
      check({tag, ".done_pulse"}, done, 0);
      check({tag, ".idle"}, state_dbg, 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      bit st;
      int bm, bw, n, e, extra_done;

      rst = 1'b1; start = 1'b0;
      match_list = '0; w_valid = '0; m_pref = '0; w_rank = '0;
      repeat (3) @(negedge clk);
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.stable", stable, 0);
      check("reset.blk_m", blocking_m, 0);
      check("reset.blk_w", blocking_w, 0);
      check("reset.state", state_dbg, 0);
      rst = 1'b0;
      @(negedge clk);

      set_identity();
      run_case("identity");

      set_identity();
      ml[0] = 1; ml[1] = 0;
      run_case("swapped");

      set_identity();
      for (int w = 0; w < W; w++) wv[w] = 0;
      run_case("empty");

      set_full_scan();
      run_case("full_scan");

      // Two women naming the same man: the higher-numbered woman keeps him.
      set_identity();
      ml[0] = 1;
      run_case("dup_man");

      // Equal ranks must not block.
      set_identity();
      ml[0] = 1; ml[1] = 0;
      rank_t[0][0] = 2; rank_t[0][1] = 2; rank_t[1][0] = 2; rank_t[1][1] = 2;
      run_case("tie_rank");

      for (int r = 0; r < 30; r++) begin
         set_random();
         run_case($sformatf("rand%0d", r));
      end

      // start pulsed during SCAN must be ignored.
      set_full_scan();
      apply();
      model(st, bm, bw, n);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      e = 0;
      while (!done && e < BUDGET) begin
         @(negedge clk);
         e++;
         if (e == W + 2) begin
            check("ignore_start.in_scan", state_dbg, 2);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("ignore_start.latency", e, W + n);
      check("ignore_start.stable", stable, st);
      extra_done = 0;
      repeat (2 * (W + M * KM)) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check("ignore_start.single_done", extra_done, 0);
      check("ignore_start.idle", state_dbg, 0);

      // Reset in the middle of SCAN: outputs return to reset values at once.
      set_full_scan();
      apply();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (W + 3) @(negedge clk);
      check("mid_rst.in_scan", state_dbg, 2);
      #2 rst = 1'b1;
      #1;
      check("mid_rst.busy", busy, 0);
      check("mid_rst.done", done, 0);
      check("mid_rst.stable", stable, 0);
      check("mid_rst.state", state_dbg, 0);
      @(negedge clk) rst = 1'b0;
      extra_done = 0;
      repeat (W + M * KM) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check("mid_rst.no_done", extra_done, 0);

      set_identity();
      ml[0] = 1; ml[1] = 0;
      run_case("after_rst");
      set_full_scan();
      run_case("after_rst_full");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
